// File: rtl/instr_fetch_unit.sv
// Instruction fetch: issues sequential imem reads, buffers in-order responses, flushes on redirect.
// Buffered instr appears one cycle after the response edge; requests stall once outstanding+buffered reach DEPTH.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        enable,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  state_t           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  entry_t           buf_q [DEPTH];

  logic [CNT_W:0]   inflight;
  logic             req_fire;
  logic             push;
  logic             pop;
  entry_t           head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Buffered entries count against the request budget so the buffer can never overflow.
  assign inflight       = {1'b0, outstanding_q} + {1'b0, count_q};
  assign imem_req_valid = (state_q == RUN) && !redirect && (inflight < DEPTH_W);
  assign imem_addr      = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push = imem_rsp_valid && !redirect && (drop_cnt_q == '0);
  assign pop  = instr_valid && instr_ready && !redirect;

  assign head        = buf_q[rd_ptr_q];
  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? head.data : '0;
  assign instr_pc    = instr_valid ? head.pc   : '0;
  assign opcode      = instr[6:0];

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
    drop_cnt_d    = drop_cnt_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable)                     state_d = RUN;
        else if (outstanding_q == '0)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;

    if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CNT_W'(1);

    if (push) begin
      resp_pc_d = resp_pc_q + 32'd4;
      wr_ptr_d  = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // Everything still in flight belongs to the old stream; a response landing now is already excluded.
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      drop_cnt_d = outstanding_q - CNT_W'(imem_rsp_valid);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      if (push) buf_q[wr_ptr_q] <= '{data: imem_rsp_data, pc: resp_pc_q};
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order memory model that can be held off.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        enable;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic        redirect;
  logic [31:0] redirect_pc;

  instr_fetch_unit dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .enable         (enable),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .opcode         (opcode),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] pend[$];
  logic [31:0] accq[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_ins[$];
  logic [31:0] pop_opc[$];
  logic        mem_hold;
  int          n0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mw(input logic [31:0] a);
    return {a[23:0], 8'h33};
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    return (i < accq.size()) ? accq[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] pc_at(input int i);
    return (i < pop_pc.size()) ? pop_pc[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] ins_at(input int i);
    return (i < pop_ins.size()) ? pop_ins[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] opc_at(input int i);
    return (i < pop_opc.size()) ? pop_opc[i] : 32'hDEAD_BEEF;
  endfunction

  // One clock: present the oldest pending response, sample handshakes, then advance past the edge.
  task automatic tick();
    logic        rsp_go;
    logic        acc;
    logic [31:0] a;
    rsp_go         = !mem_hold && (pend.size() != 0);
    imem_rsp_valid = rsp_go;
    imem_rsp_data  = rsp_go ? mw(pend[0]) : 32'h0;
    #1;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_addr;
    if (instr_valid && instr_ready && !redirect) begin
      pop_pc.push_back(instr_pc);
      pop_ins.push_back(instr);
      pop_opc.push_back({25'h0, opcode});
    end
    @(posedge clk);
    if (rsp_go) void'(pend.pop_front());
    if (acc) begin
      pend.push_back(a);
      accq.push_back(a);
    end
    #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
  endtask

  task automatic do_reset();
    arst_n         = 1'b0;
    enable         = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    imem_req_ready = 1'b1;
    mem_hold       = 1'b0;
    pend.delete();
    accq.delete();
    pop_pc.delete();
    pop_ins.delete();
    pop_opc.delete();
    tick();
    tick();
    arst_n = 1'b1;
  endtask

  // Leaves the DUT in RUN with requests 0x8 and 0xC outstanding, nothing buffered.
  task automatic setup_two_out();
    do_reset();
    enable      = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 30 && accq.size() < 3; i++) tick();
    mem_hold = 1'b1;
    for (int i = 0; i < 30 && accq.size() < 4; i++) tick();
    chk("two_pend", 32'(pend.size()), 32'd2);
    chk("two_acc2", acc_at(2), 32'h8);
    chk("two_acc3", acc_at(3), 32'hC);
    chk("two_stall", 32'(imem_req_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    arst_n         = 1'b0;
    enable         = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    mem_hold       = 1'b0;
    #2;
    chk("rst_req_vld", 32'(imem_req_valid), 32'd0);
    chk("rst_instr_vld", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_opcode", 32'(opcode), 32'h0);
    @(posedge clk);
    #1;

    // Streaming fetch from reset
    do_reset();
    enable      = 1'b1;
    instr_ready = 1'b1;
    tick();
    chk("s1_req_vld", 32'(imem_req_valid), 32'd1);
    chk("s1_req_addr", imem_addr, 32'h0);
    repeat (12) tick();
    for (int i = 0; i < 4; i++) chk("s1_addr_seq", acc_at(i), 32'(i * 4));
    chk("s1_pop0_pc", pc_at(0), 32'h0);
    chk("s1_pop0_ins", ins_at(0), 32'h0000_0033);
    chk("s1_pop0_opc", opc_at(0), 32'h33);
    chk("s1_pop1_pc", pc_at(1), 32'h4);
    chk("s1_pop1_ins", ins_at(1), 32'h0000_0433);

    // Consumer stalled: buffer fills, requests stop, then resume in order
    do_reset();
    enable = 1'b1;
    repeat (6) tick();
    chk("s2_full_stall", 32'(imem_req_valid), 32'd0);
    chk("s2_acc_n", 32'(accq.size()), 32'd2);
    chk("s2_head_pc", instr_pc, 32'h0);
    repeat (3) tick();
    chk("s2_still_stall", 32'(imem_req_valid), 32'd0);
    chk("s2_acc_n_hold", 32'(accq.size()), 32'd2);
    instr_ready = 1'b1;
    repeat (8) tick();
    chk("s2_pop0_pc", pc_at(0), 32'h0);
    chk("s2_pop1_pc", pc_at(1), 32'h4);
    chk("s2_resume", acc_at(2), 32'h8);

    // Redirect with two requests outstanding
    setup_two_out();
    redirect_pc = 32'h100;
    redirect    = 1'b1;
    #1;
    chk("s3_redir_noreq", 32'(imem_req_valid), 32'd0);
    tick();
    redirect = 1'b0;
    chk("s3_drop_cnt", 32'(dut.drop_cnt_q), 32'd2);
    n0       = pop_pc.size();
    mem_hold = 1'b0;
    for (int i = 0; i < 30 && accq.size() < 5; i++) tick();
    chk("s3_new_addr", acc_at(4), 32'h100);
    for (int i = 0; i < 30 && pop_pc.size() <= n0; i++) tick();
    chk("s3_first_pc", pc_at(n0), 32'h100);
    chk("s3_first_ins", ins_at(n0), 32'h0001_0033);

    // Redirect coinciding with a response
    setup_two_out();
    redirect_pc = 32'h200;
    redirect    = 1'b1;
    mem_hold    = 1'b0;
    tick();
    redirect = 1'b0;
    chk("s4_drop_cnt", 32'(dut.drop_cnt_q), 32'd1);
    chk("s4_pend", 32'(pend.size()), 32'd1);
    n0 = pop_pc.size();
    tick();
    chk("s4_drop_done", 32'(dut.drop_cnt_q), 32'd0);
    for (int i = 0; i < 30 && accq.size() < 5; i++) tick();
    chk("s4_new_addr", acc_at(4), 32'h200);
    for (int i = 0; i < 30 && pop_pc.size() <= n0; i++) tick();
    chk("s4_first_pc", pc_at(n0), 32'h200);
    chk("s4_first_ins", ins_at(n0), 32'h0002_0033);

    // Disable with requests in flight: drain, idle, entries kept
    setup_two_out();
    enable      = 1'b0;
    instr_ready = 1'b0;
    tick();
    chk("s5_drain_noreq", 32'(imem_req_valid), 32'd0);
    mem_hold = 1'b0;
    repeat (5) tick();
    chk("s5_acc_n", 32'(accq.size()), 32'd4);
    chk("s5_idle_noreq", 32'(imem_req_valid), 32'd0);
    chk("s5_head_vld", 32'(instr_valid), 32'd1);
    chk("s5_head_pc", instr_pc, 32'h8);
    chk("s5_head_ins", instr, 32'h0000_0833);
    n0          = pop_pc.size();
    instr_ready = 1'b1;
    repeat (2) tick();
    chk("s5_pop0_pc", pc_at(n0), 32'h8);
    chk("s5_pop1_pc", pc_at(n0 + 1), 32'hC);
    chk("s5_empty", 32'(instr_valid), 32'd0);

    // Async reset with a full buffer
    do_reset();
    enable = 1'b1;
    repeat (8) tick();
    chk("s6_full_vld", 32'(instr_valid), 32'd1);
    arst_n = 1'b0;
    #1;
    chk("s6_rst_vld", 32'(instr_valid), 32'd0);
    chk("s6_rst_instr", instr, 32'h0);
    chk("s6_rst_pc", instr_pc, 32'h0);
    chk("s6_rst_opc", 32'(opcode), 32'h0);
    chk("s6_rst_req", 32'(imem_req_valid), 32'd0);
    pend.delete();
    accq.delete();
    tick();
    arst_n = 1'b1;
    tick();
    chk("s6_req_vld", 32'(imem_req_valid), 32'd1);
    chk("s6_req_addr", imem_addr, 32'h0);
    redirect_pc = 32'h40;
    redirect    = 1'b1;
    #1;
    chk("s6_redir_noreq", 32'(imem_req_valid), 32'd0);
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 30 && accq.size() < 1; i++) tick();
    chk("s6_redir_addr", acc_at(0), 32'h40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, instruction buffer entries; also the maximum number of in-flight memory requests.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on the rising edge.
- arst_n, in, 1, asynchronous active-low reset.
- enable, in, 1, fetch permission.
- imem_req_valid, out, 1, memory read request.
- imem_req_ready, in, 1, memory accepts the request this cycle.
- imem_addr, out, 32, request address.
- imem_rsp_valid, in, 1, one-cycle pulse per response; responses arrive in order, at least 1 cycle after acceptance.
- imem_rsp_data, in, 32, instruction word.
- instr_valid, out, 1, buffer head valid.
- instr_ready, in, 1, consumer accepts the head.
- instr, out, 32, head instruction word.
- instr_pc, out, 32, head instruction address.
- opcode, out, 7, instr[6:0]; feeds the control unit.
- redirect, in, 1, branch/jump taken pulse.
- redirect_pc, in, 32, new fetch address.

Function
REQ-003 The FSM SHALL have three states (IDLE, RUN, DRAIN) with these transitions:
- IDLE->RUN when enable=1.
- RUN->DRAIN when enable=0.
- DRAIN->RUN when enable=1.
- DRAIN->IDLE when enable=0 and outstanding=0.

REQ-004 imem_req_valid SHALL be 1 only when all of the following hold: state=RUN, redirect=0, and outstanding+count<DEPTH. imem_addr SHALL equal fetch_pc.

REQ-005 A request is accepted on imem_req_valid & imem_req_ready. On acceptance: fetch_pc += 4 (mod 2^32) and outstanding += 1. No address stability is required across non-accepted cycles.

REQ-006 Each imem_rsp_valid SHALL decrement outstanding.
- If drop_cnt>0: discard the response and decrement drop_cnt.
- Otherwise: push {imem_rsp_data, resp_pc} into the buffer and do resp_pc += 4.

REQ-007 Buffer outputs and pop:
- instr_valid = (count>0).
- instr, instr_pc and opcode SHALL present the head entry, and SHALL be 0 when empty.
- A pop occurs on instr_valid & instr_ready.

REQ-008 Push and pop in the same cycle SHALL leave count unchanged and preserve order. Overflow is impossible by REQ-004, and the design SHALL NOT rely on imem throttling for this.

REQ-009 Latency: an instruction pushed at edge N SHALL be visible at the outputs in the cycle after edge N (no combinational rsp-to-instr path).

REQ-010 Redirect=1 in any state SHALL, at that edge:
- flush the buffer (count=0, regardless of instr_ready);
- set fetch_pc=redirect_pc and resp_pc=redirect_pc;
- set drop_cnt = outstanding - imem_rsp_valid (every still-pending response is dropped).
No request SHALL be issued in the redirect cycle.

REQ-011 A response arriving in a redirect cycle SHALL be discarded.

REQ-012 Back-to-back redirects SHALL each reapply REQ-010; the last one wins.

REQ-013 Entering DRAIN or IDLE SHALL NOT flush the buffer. The consumer SHALL still be able to pop entries while in DRAIN or IDLE.

REQ-014 Counters:
- outstanding and drop_cnt SHALL each be 0..DEPTH.
- drop_cnt ≤ outstanding SHALL always hold.
- The widths of both counters SHALL be clog2(DEPTH+1).

Reset
REQ-015 While arst_n=0, the block SHALL immediately force:
- state=IDLE;
- fetch_pc=resp_pc=RESET_PC;
- count=outstanding=drop_cnt=0;
- imem_req_valid=0, instr_valid=0, and instr, instr_pc, opcode all 0.

REQ-016 Responses for requests accepted before a reset SHALL never be delivered. The integration SHALL reset the memory together with this block.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Reset release, enable=1, req_ready=1, 1-cycle response latency, instr_ready=1, word 0x00000033 at address 0 -> first request addr 0x0 in the first RUN cycle; instr_valid=1 with instr_pc=0x0 and opcode=7'h33; subsequent addresses 0x4, 0x8, ... gap-free.
- instr_ready=0 held -> after 2 responses, count=2 and imem_req_valid stays 0; then instr_ready=1 -> pops in order with pc 0x0 then 0x4, and fetching resumes at 0x8.
- Two outstanding requests (addresses 0x8 and 0xC) plus redirect to 0x100 -> both responses dropped; next request addr 0x100; first delivered instr_pc=0x100.
- Redirect in the same cycle as a response, with outstanding=2 -> that response discarded; drop_cnt=1; exactly one further response dropped.
- enable=0 with 2 outstanding -> DRAIN; both responses buffered; then IDLE with no new requests; the buffered entries remain poppable.
- arst_n asserted mid-stream with a full buffer -> outputs 0 immediately, without a clock; after release, first request addr = RESET_PC.
